seg7_scan_ctrl: RTL and testbench

Parametrised multi-digit 7-segment scan controller, next generation of the board's 8-digit keypad display driver. Drives NUM_DIGITS time-multiplexed digits with full hex decode (0-F), per-digit enable, decimal point and blink masks, and optional leading-zero blanking. A double-buffered load interface commits new display content only at frame boundaries, so digits never tear. Sits between the keypad/number logic and the board's led_en/led_cx pins.

---
 rtl/seg7_scan_ctrl.sv | 152 +++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed hex 7-segment scanner with frame-synchronous double-buffered content,
// per-digit enable/dp/blink masks and optional leading-zero blanking.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 200000,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   digit_data,
  input  logic [NUM_DIGITS-1:0]     digit_en,
  input  logic [NUM_DIGITS-1:0]     dp_mask,
  input  logic [NUM_DIGITS-1:0]     blink_mask,
  input  logic                      lz_blank,
  output logic [NUM_DIGITS-1:0]     led_en,
  output logic [7:0]                led_cx,
  output logic                      frame_done
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] data;
    logic [NUM_DIGITS-1:0]   en;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   bm;
  } disp_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'h0: seg_decode = 7'b0000001;
      4'h1: seg_decode = 7'b1001111;
      4'h2: seg_decode = 7'b0010010;
      4'h3: seg_decode = 7'b0000110;
      4'h4: seg_decode = 7'b1001100;
      4'h5: seg_decode = 7'b0100100;
      4'h6: seg_decode = 7'b0100000;
      4'h7: seg_decode = 7'b0001111;
      4'h8: seg_decode = 7'b0000000;
      4'h9: seg_decode = 7'b0001100;
      4'hA: seg_decode = 7'b0001000;
      4'hB: seg_decode = 7'b1100000;
      4'hC: seg_decode = 7'b0110001;
      4'hD: seg_decode = 7'b1000010;
      4'hE: seg_decode = 7'b0110000;
      default: seg_decode = 7'b0111000;
    endcase
  endfunction

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [BW-1:0]         blink_cnt;
  logic                  phase_hidden;
  logic                  pend_vld;
  disp_t                 pend;
  disp_t                 act;
  disp_t                 in_set;
  logic                  tick;
  logic                  wrap;
  logic [3:0]            nib;
  logic                  cur_en;
  logic                  cur_dp;
  logic                  cur_bm;
  logic                  nz_above;
  logic                  lz_hit;
  logic                  blank;
  logic [NUM_DIGITS-1:0] en_nxt;
  logic [7:0]            cx_nxt;

  assign in_set = '{data: digit_data, en: digit_en, dp: dp_mask, bm: blink_mask};
  assign tick   = (cnt == CNT_LAST);
  assign wrap   = tick && (idx == IDX_LAST);

  // Leading-zero test: current digit is zero and no enabled nonzero digit sits above it.
  always_comb begin
    nib      = 4'h0;
    cur_en   = 1'b0;
    cur_dp   = 1'b0;
    cur_bm   = 1'b0;
    nz_above = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib    = act.data[4*i +: 4];
        cur_en = act.en[i];
        cur_dp = act.dp[i];
        cur_bm = act.bm[i];
      end
      if ((IW'(i) > idx) && act.en[i] && (act.data[4*i +: 4] != 4'h0))
        nz_above = 1'b1;
    end
    lz_hit = lz_blank && (idx != '0) && (nib == 4'h0) && !nz_above;
    blank  = !cur_en || lz_hit || (cur_bm && phase_hidden);
    for (int i = 0; i < NUM_DIGITS; i++)
      en_nxt[i] = blank || (idx != IW'(i));
    cx_nxt = blank ? 8'hFF : {seg_decode(nib), ~cur_dp};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      idx          <= '0;
      blink_cnt    <= '0;
      phase_hidden <= 1'b0;
      pend_vld     <= 1'b0;
      pend         <= '0;
      act          <= '0;
      led_en       <= '1;
      led_cx       <= 8'hFF;
      frame_done   <= 1'b0;
    end else begin
      led_en     <= en_nxt;
      led_cx     <= cx_nxt;
      frame_done <= wrap;

      if (tick) begin
        cnt <= '0;
        idx <= wrap ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (load) begin
        pend     <= in_set;
        pend_vld <= 1'b1;
      end

      // A load coinciding with the boundary bypasses the pending stage.
      if (wrap) begin
        if (load) begin
          act      <= in_set;
          pend_vld <= 1'b0;
        end else if (pend_vld) begin
          act      <= pend;
          pend_vld <= 1'b0;
        end
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt    <= '0;
          phase_hidden <= ~phase_hidden;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomised scoreboard bench for seg7_scan_ctrl (4 digits, 4 clk per digit, 2-frame blink).
module tb_seg7_scan_ctrl;
  localparam int N  = 4;
  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FR = N * SD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic        lz_blank = 1'b0;
  logic [15:0] digit_data = '0;
  logic [3:0]  digit_en = '0;
  logic [3:0]  dp_mask = '0;
  logic [3:0]  blink_mask = '0;
  logic [3:0]  led_en;
  logic [7:0]  led_cx;
  logic        frame_done;

  seg7_scan_ctrl #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .digit_data(digit_data),
    .digit_en(digit_en), .dp_mask(dp_mask), .blink_mask(blink_mask),
    .lz_blank(lz_blank), .led_en(led_en), .led_cx(led_cx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  en;
    logic [3:0]  dp;
    logic [3:0]  bm;
  } set_t;

  set_t        act;
  set_t        pend;
  bit          pflag;
  int          k;
  bit          run;
  logic [12:0] expq[$];
  int          passed;
  int          total;

  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'h0: seg = 7'b0000001;  4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;  4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;  4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;  4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;  4'h9: seg = 7'b0001100;
      4'hA: seg = 7'b0001000;  4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;  4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;  default: seg = 7'b0111000;
    endcase
  endfunction

  // Expected {led_en, led_cx, frame_done} registered from cycle kk since reset release.
  function automatic logic [12:0] expect_out(input int kk, input set_t s, input logic lz);
    int         d;
    int         f;
    int         hi;
    bit         hidden;
    bit         show;
    logic [3:0] v;
    logic [3:0] en;
    logic [7:0] cx;
    d      = (kk / SD) % N;
    f      = kk / FR;
    hidden = ((f / BF) % 2) == 1;
    hi     = -1;
    for (int j = 0; j < N; j++)
      if (s.en[j] && s.d[4*j +: 4] != 4'h0) hi = j;
    v    = s.d[4*d +: 4];
    show = s.en[d] && !(lz && d > 0 && d > hi) && !(s.bm[d] && hidden);
    en   = show ? ~(4'b0001 << d) : 4'hF;
    cx   = show ? {seg(v), ~s.dp[d]} : 8'hFF;
    return {en, cx, ((kk + 1) % FR) == 0};
  endfunction

  task automatic chk(input string name, input logic [12:0] got, input logic [12:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s k=%0d: got en=%h cx=%h fd=%b, expected en=%h cx=%h fd=%b",
                  name, k, got[12:9], got[8:1], got[0], exp[12:9], exp[8:1], exp[0]);
  endtask

  // Drive one cycle of inputs, record the expected response, advance the model.
  task automatic step(input bit ld, input set_t s, input bit lz);
    load = ld;
    {digit_data, digit_en, dp_mask, blink_mask} = s;
    lz_blank = lz;
    expq.push_back(expect_out(k, act, lz));
    if (ld) begin
      pend  = s;
      pflag = 1'b1;
    end
    if ((k % FR) == FR - 1 && pflag) begin
      act   = pend;
      pflag = 1'b0;
    end
    k++;
    @(negedge clk);
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    k     = 0;
    act   = '0;
    pend  = '0;
    pflag = 1'b0;
    run   = 1'b1;
  endtask

  always @(posedge clk) begin
    #1;
    if (run) begin
      if (expq.size() == 0) begin
        total++;
        $display("FAIL scoreboard_underflow: got output with no expectation, expected a queued entry");
      end else begin
        chk("scan", {led_en, led_cx, frame_done}, expq.pop_front());
      end
    end
  end

  initial begin
    set_t        s;
    logic [31:0] r;
    passed = 0;
    total  = 0;
    run    = 1'b0;
    k      = 0;
    act    = '0;
    pend   = '0;
    pflag  = 1'b0;

    @(negedge clk);
    chk("reset_state", {led_en, led_cx, frame_done}, {4'hF, 8'hFF, 1'b0});
    release_reset();

    repeat (40) step(1'b0, '0, 1'b0);

    s = {16'h12AF, 4'hF, 4'b0100, 4'h0};
    step(1'b1, s, 1'b0);
    repeat (48) step(1'b0, s, 1'b0);

    while ((k % FR) != FR - 1) step(1'b0, s, 1'b0);
    s = {16'h8C3D, 4'hF, 4'b1001, 4'h0};
    step(1'b1, s, 1'b0);
    repeat (32) step(1'b0, s, 1'b0);

    s = {16'h0050, 4'hF, 4'h0, 4'h0};
    step(1'b1, s, 1'b1);
    repeat (40) step(1'b0, s, 1'b1);
    s = {16'h0000, 4'hF, 4'h0, 4'h0};
    step(1'b1, s, 1'b1);
    repeat (40) step(1'b0, s, 1'b1);

    s = {16'h4321, 4'hF, 4'h0, 4'b0001};
    step(1'b1, s, 1'b0);
    repeat (120) step(1'b0, s, 1'b0);

    for (int i = 0; i < 800; i++) begin
      r = $urandom;
      s = r[27:0];
      step($urandom_range(0, 7) == 0, s, 1'($urandom_range(0, 1)));
    end

    while ((k % FR) != 5) step(1'b0, s, 1'b0);
    s = {16'h9876, 4'hF, 4'hF, 4'h0};
    step(1'b1, s, 1'b0);
    step(1'b0, s, 1'b0);
    run   = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {led_en, led_cx, frame_done}, {4'hF, 8'hFF, 1'b0});
    expq.delete();
    release_reset();
    repeat (48) step(1'b0, '0, 1'b0);

    run = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
